// File: rtl/cpu_pkg.sv
// Shared core definitions: fetch-state encoding, branch condition codes,
// NOP encoding and the default reset PC.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_VALID = 2'd2,
    ST_TRAP  = 2'd3
  } fetch_state_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Debug view of the fetch stage for checkers and waveform inspection.
  typedef struct packed {
    fetch_state_e state;
    logic         taken;
  } fetch_dbg_t;

endpackage

// File: rtl/ifetch_if.sv
// Instruction-memory fetch bus between the fetch stage (master) and memory.
// Handshake: a transfer happens on a rising edge where imem_req & imem_ready;
// imem_rdata is valid in that same cycle, and imem_req/imem_addr stay stable
// until it does.
interface ifetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr,
                  input  imem_ready, input imem_rdata);
  modport slave  (input  imem_req, input imem_addr,
                  output imem_ready, output imem_rdata);
endinterface

// File: rtl/ifetch_npc_calc.sv
// Next-PC selection for the fetch stage: jal, jalr, taken branch, or pc+4.
module npc_calc
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] imm,
  input  logic [31:0] rs1_data,
  input  logic        Branch,
  input  logic        jal,
  input  logic        jalr,
  input  logic [2:0]  Funct3,
  input  logic        zero,
  input  logic        alu_lsb,
  output logic [31:0] next_pc,
  output logic        taken
);

  logic cond;

  always_comb begin
    cond = 1'b0;
    case (Funct3)
      F3_BEQ:           cond = zero;
      F3_BNE:           cond = !zero;
      F3_BLT, F3_BLTU:  cond = alu_lsb;
      F3_BGE, F3_BGEU:  cond = !alu_lsb;
      default:          cond = 1'b0;
    endcase
    taken = Branch & cond;

    // jal outranks jalr outranks branch; the decoder should never raise two.
    if (jal)
      next_pc = pc + imm;
    else if (jalr)
      next_pc = (rs1_data + imm) & ~32'h1;
    else if (taken)
      next_pc = pc + imm;
    else
      next_pc = pc + 32'd4;
  end

endmodule

// File: rtl/ifetch.sv
// Instruction-fetch / next-PC stage: owns the architectural PC, fetches over
// the imem bus, holds the word for the decoder until commit, then redirects.
module ifetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  ifetch_if.master    imem,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        commit,
  input  logic        Branch,
  input  logic        jal,
  input  logic        jalr,
  input  logic [2:0]  Funct3,
  input  logic        zero,
  input  logic        alu_lsb,
  input  logic [31:0] imm,
  input  logic [31:0] rs1_data,
  output logic        misalign,
  output fetch_dbg_t  dbg
);

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] FETCH = ST_FETCH;
  localparam logic [1:0] VALID = ST_VALID;
  localparam logic [1:0] TRAP  = ST_TRAP;

  logic [1:0]  state;
  logic [31:0] next_pc;
  logic        taken;

  npc_calc u_npc (
    .pc       (pc),
    .imm      (imm),
    .rs1_data (rs1_data),
    .Branch   (Branch),
    .jal      (jal),
    .jalr     (jalr),
    .Funct3   (Funct3),
    .zero     (zero),
    .alu_lsb  (alu_lsb),
    .next_pc  (next_pc),
    .taken    (taken)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      instr    <= NOP_INSTR;
      misalign <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= FETCH;
        FETCH: begin
          if (imem.imem_ready) begin
            instr <= imem.imem_rdata;
            state <= VALID;
          end
        end
        VALID: begin
          // A misaligned target leaves pc on the faulting instruction.
          if (commit) begin
            if (next_pc[1:0] != 2'b00) begin
              state    <= TRAP;
              misalign <= 1'b1;
            end else begin
              pc    <= next_pc;
              state <= FETCH;
            end
          end
        end
        default: misalign <= 1'b1;
      endcase
    end
  end

  assign imem.imem_req  = (state == FETCH);
  assign imem.imem_addr = pc;
  assign instr_valid    = (state == VALID);
  assign pc_plus4       = pc + 32'd4;
  assign dbg.state      = fetch_state_e'(state);
  assign dbg.taken      = taken;

endmodule

// File: doc/ifetch.md
# ifetch

Instruction-fetch and next-PC stage of the RISC-V core. Holds the architectural PC, fetches the instruction word from instruction memory over a ready-based handshake, and presents it with its PC to the decoder. Once the core commits the current instruction, the stage computes the next PC from the decoder's Branch/jal/jalr flags, the branch Funct3, the ALU flags and the immediate, then fetches again. The PC register is updated by this stage only.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned.

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request, asserted in FETCH.
- imem_addr  out  32  fetch address, equal to pc.
- imem_ready  in  1  memory accepts the request and returns imem_rdata in the same cycle.
- imem_rdata  in  32  instruction word, valid when imem_req & imem_ready.
- instr  out  32  registered instruction presented to the decoder.
- instr_valid  out  1  instr/pc are valid, waiting for commit.
- pc  out  32  PC of instr.
- pc_plus4  out  32  pc+4, the link value for jal/jalr writeback.
- commit  in  1  core has finished instr; sampled only when instr_valid=1.
- Branch, jal, jalr  in  1 each  decoder class flags for instr.
- Funct3  in  3  branch condition code.
- zero  in  1  ALU zero flag (SUB result).
- alu_lsb  in  1  ALU result bit 0 (SLT/SLTU result).
- imm  in  32  sign-extended B/J/I immediate.
- rs1_data  in  32  rs1 register value, used by jalr.
- misalign  out  1  sticky fault: computed target not word-aligned.

## Operation
- States: IDLE, FETCH, VALID, TRAP.
- IDLE -> FETCH unconditionally. IDLE is entered only from reset.
- FETCH:
  - imem_req=1 and imem_addr=pc, both stable until imem_ready.
  - On imem_ready: instr <= imem_rdata and go to VALID.
- VALID:
  - instr_valid=1 and imem_req=0.
  - commit=0: hold everything.
  - commit=1 with aligned next_pc: pc <= next_pc and go to FETCH.
  - commit=1 with next_pc[1:0]!=0: go to TRAP. pc is not updated.
- TRAP: misalign=1, imem_req=0, instr_valid=0. Held until reset.
- next_pc, by priority:
  - jal: pc+imm.
  - jalr: (rs1_data+imm) & ~32'h1.
  - Branch & taken: pc+imm.
  - Otherwise: pc+4.
- Branch taken condition by Funct3:
  - 000 beq: zero.
  - 001 bne: !zero.
  - 100 blt and 110 bltu: alu_lsb.
  - 101 bge and 111 bgeu: !alu_lsb.
  - 010 and 011: not taken.
- Arithmetic is 32-bit modulo; wrap past 32'hFFFF_FFFC is legal, so pc+4 yields 0.
- The alignment check applies to every next_pc, including the pc+4 path. That path can never fault.
- commit outside VALID is ignored. imem_ready outside FETCH is ignored.

## Timing
- Reset values: state=IDLE, pc=RESET_PC, pc_plus4=RESET_PC+4, instr=32'h0000_0013 (nop), instr_valid=0, imem_req=0, imem_addr=RESET_PC, misalign=0.
- instr, pc and misalign are registered. instr_valid, imem_req, imem_addr and pc_plus4 are decoded from state and pc.
- First edge after reset release: FETCH. With imem_ready=1, instr_valid rises at the following edge.
- Best-case throughput is one instruction per 2 cycles (FETCH + VALID with commit=1). Each cycle of imem_ready=0 adds one cycle.
- The decoder and branch inputs are combinational from instr. They are sampled on the commit edge only.
- Reset asserted mid-fetch abandons the request. A late imem_ready after reset is not captured.

## Structure
- Shared package cpu_pkg holds:
  - the fetch-state enum (2-bit);
  - the branch Funct3 constants (BEQ=000, BNE=001, BLT=100, BGE=101, BLTU=110, BGEU=111);
  - the NOP encoding 32'h0000_0013;
  - the default RESET_PC.
- One combinational sub-module, npc_calc: inputs pc, imm, rs1_data, Branch, jal, jalr, Funct3, zero and alu_lsb; outputs next_pc and taken.
- The FSM and registers stay in ifetch.

## Test plan
- Reset, then imem_ready=1 and commit=1 every VALID cycle with nop instructions -> imem_addr sequence 0,4,8,C; instr_valid high every second cycle.
- At pc=0x10, Branch=1, Funct3=000, zero=1, imm=0xFFFFFFF8 -> next fetch at 0x08. Same stimulus with zero=0 -> fetch at 0x14.
- At pc=0x20, jal=1, imm=0x100 -> pc_plus4=0x24 during VALID; next fetch at 0x120. jalr with rs1_data=0x203, imm=1 -> fetch at 0x204.
- Hold imem_ready=0 for 3 cycles in FETCH -> imem_req and imem_addr stable; instr_valid rises one edge after imem_ready=1.
- jal with imm=0x2 at pc=0x40 -> TRAP: misalign=1, pc stays 0x40, no further imem_req until rst.
- Assert rst during FETCH with imem_ready arriving in the same cycle as release -> pc=RESET_PC, instr=nop, instr_valid=0, data not captured.
